// File: rtl/free_list.sv
// Walks a linked list of card nodes in the shared card RAM and releases each one
// by writing its word to zero, which clears the allocation flag in bit 31.
module free_list #(
    parameter int MAX_NODES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       head,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] freed_count,
    output logic [9:0]       ram_address,
    output logic             ram_clock,
    output logic [31:0]      ram_data,
    output logic             ram_wren,
    input  logic [31:0]      ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CHECK,
        S_WR,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       cur_q, cur_d;
    logic [9:0]       nxt_q, nxt_d;
    logic [9:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cntInc;
    logic             unusedRamBits;

    assign cntInc = cnt_q + CNT_W'(1);

    // State register plus the walk pointers, count, error flag and RAM address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Each node costs RD, WAIT, CHECK, WR; the address set in RD is held
    // through WR so the write lands on the node that was just read.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (head == 10'd0) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = head;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                addr_d  = cur_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // An unallocated node means a corrupt list or a revisit.
                if (!ram_q[31]) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    nxt_d   = ram_q[9:0];
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d = cntInc;
                if (nxt_q == 10'd0) begin
                    state_d = S_DONE;
                end else if (cntInc == CNT_W'(MAX_NODES)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cur_d   = nxt_q;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign ram_wren      = (state_q == S_WR);
    assign error         = err_q;
    assign freed_count   = cnt_q;
    assign ram_address   = addr_q;
    assign ram_clock     = clock;
    assign ram_data      = 32'd0;
    assign unusedRamBits = ^ram_q[30:10];

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: a card RAM model, a list-walking reference model and a
// per-cycle compare process that checks writes, done/busy timing and results.
module tb_free_list;

   localparam int MAXN = 64;
   localparam int CW   = 7;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [9:0]    head;
   logic          busy;
   logic          done;
   logic          error;
   logic [CW-1:0] freedCount;
   logic [9:0]    ramAddress;
   logic          ramClock;
   logic [31:0]   ramData;
   logic          ramWren;
   logic [31:0]   ramQ = 32'd0;

   logic [31:0]   mem [1024];
   logic [31:0]   initMem [1024];
   logic [31:0]   modelMem [1024];
   logic          loadReq;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   bit            checkEn = 1'b0;
   bit            opDone = 1'b0;
   int            expLatency;
   int            expCount;
   int            expErr;
   logic [9:0]    expWrites [$];

   free_list #(.MAX_NODES(MAXN), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .head        (head),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .freed_count (freedCount),
      .ram_address (ramAddress),
      .ram_clock   (ramClock),
      .ram_data    (ramData),
      .ram_wren    (ramWren),
      .ram_q       (ramQ)
   );

   // Free-running 10-time-unit system clock.
   always #5 clock = ~clock;

   // Card RAM: one registered read stage behind the registered address, and a
   // bulk load path so the memory image has a single writing process.
   always @(posedge ramClock) begin
      if (loadReq) begin
         mem <= initMem;
      end else if (ramWren) begin
         mem[ramAddress] <= ramData;
      end
      ramQ <= mem[ramAddress];
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mkNode(input logic [3:0] v, input logic [1:0] s, input logic [9:0] nx);
      return {1'b1, 15'd0, v, s, nx};
   endfunction

   task automatic clearImage();
      for (int i = 0; i < 1024; i++) initMem[i] = 32'd0;
   endtask

   task automatic loadImage();
      @(posedge clock);
      #1 loadReq = 1'b1;
      @(posedge clock);
      #1 loadReq = 1'b0;
   endtask

   // Reference walk: visit nodes from the head, free allocated ones, stop on a
   // null next, an unallocated node, or after MAXN frees with more to go.
   task automatic computeModel(input logic [9:0] h);
      logic [9:0]  cur;
      logic [31:0] word;
      int          cycles;
      modelMem = initMem;
      expWrites.delete();
      expCount = 0;
      expErr   = 0;
      cycles   = 0;
      cur      = h;
      while (cur != 10'd0) begin
         word   = modelMem[cur];
         cycles = cycles + 3;
         if (!word[31]) begin
            expErr = 1;
            break;
         end
         modelMem[cur] = 32'd0;
         expWrites.push_back(cur);
         expCount++;
         cycles++;
         if (word[9:0] == 10'd0) break;
         if (expCount == MAXN) begin
            expErr = 1;
            break;
         end
         cur = word[9:0];
      end
      expLatency = cycles + 1;
   endtask

   // Per-cycle comparison against the model while an operation is in flight.
   always @(negedge clock) begin
      if (checkEn) begin
         cyc++;
         if (ramWren) begin
            if (expWrites.size() == 0) begin
               checkVal("unexpected write", {22'd0, ramAddress}, 32'h0000_FFFF);
            end else begin
               checkVal("write address", {22'd0, ramAddress}, {22'd0, expWrites.pop_front()});
            end
            checkVal("write data", ramData, 32'd0);
         end
         checkVal("done", {31'd0, done}, {31'd0, cyc == expLatency});
         checkVal("busy", {31'd0, busy}, {31'd0, cyc <= expLatency});
         if (cyc >= expLatency) begin
            checkVal("freed_count", {25'd0, freedCount}, expCount);
            checkVal("error", {31'd0, error}, expErr);
         end
         if (cyc == expLatency + 2) begin
            checkVal("writes remaining", expWrites.size(), 0);
            checkEn = 1'b0;
            opDone  = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name);
      int bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== modelMem[i]) bad++;
      checkVal({name, " ram image"}, bad, 0);
   endtask

   task automatic applyStimulus(input string name, input logic [9:0] h, input int litLat,
                                input int litCnt, input int litErr, input bit pokeBusy);
      loadImage();
      computeModel(h);
      checkVal({name, " model latency"}, expLatency, litLat);
      checkVal({name, " model count"}, expCount, litCnt);
      checkVal({name, " model error"}, expErr, litErr);
      @(posedge clock);
      #1 start = 1'b1;
      head = h;
      @(posedge clock);
      #1 start = 1'b0;
      head   = 10'h2AA;
      cyc    = 0;
      opDone = 1'b0;
      checkEn = 1'b1;
      if (pokeBusy) begin
         @(posedge clock);
         #1 start = 1'b1;
         head = 10'h060;
         @(posedge clock);
         #1 start = 1'b0;
         repeat (2) @(posedge clock);
         #1 start = 1'b1;
         head = 10'h040;
         @(posedge clock);
         #1 start = 1'b0;
      end
      for (int i = 0; i < expLatency + 20 && !opDone; i++) @(negedge clock);
      if (!opDone) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s timeout: got no completion expected done at cycle %0d", name, expLatency);
         checkEn = 1'b0;
      end
      checkOutput(name);
   endtask

   task automatic resetMidWalk();
      clearImage();
      initMem[10'h020] = mkNode(4'h2, 2'd0, 10'h040);
      initMem[10'h040] = mkNode(4'h3, 2'd1, 10'h060);
      initMem[10'h060] = mkNode(4'h4, 2'd2, 10'h000);
      loadImage();
      @(posedge clock);
      #1 start = 1'b1;
      head = 10'h020;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (5) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      checkVal("reset busy", {31'd0, busy}, 0);
      checkVal("reset done", {31'd0, done}, 0);
      checkVal("reset wren", {31'd0, ramWren}, 0);
      checkVal("reset freed_count", {25'd0, freedCount}, 0);
      repeat (12) @(posedge clock);
      #1;
      checkVal("reset node1 cleared", mem[10'h020], 32'd0);
      checkVal("reset node2 kept", mem[10'h040], mkNode(4'h3, 2'd1, 10'h060));
      checkVal("reset node3 kept", mem[10'h060], mkNode(4'h4, 2'd2, 10'h000));
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      head    = 10'd0;
      loadReq = 1'b0;
      clearImage();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkVal("reset state busy", {31'd0, busy}, 0);
      checkVal("reset state done", {31'd0, done}, 0);
      checkVal("reset state error", {31'd0, error}, 0);
      checkVal("reset state count", {25'd0, freedCount}, 0);
      checkVal("reset state addr", {22'd0, ramAddress}, 0);
      checkVal("reset state wren", {31'd0, ramWren}, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      clearImage();
      initMem[10'h020] = 32'h8000_5C00;
      applyStimulus("single", 10'h020, 5, 1, 0, 1'b0);

      clearImage();
      initMem[10'h020] = mkNode(4'hA, 2'd0, 10'h040);
      initMem[10'h040] = mkNode(4'hB, 2'd1, 10'h060);
      initMem[10'h060] = mkNode(4'hC, 2'd2, 10'h000);
      applyStimulus("three", 10'h020, 13, 3, 0, 1'b1);

      clearImage();
      initMem[10'h020] = mkNode(4'h1, 2'd3, 10'h000);
      applyStimulus("empty", 10'h000, 1, 0, 0, 1'b0);

      clearImage();
      initMem[10'h020] = mkNode(4'h7, 2'd2, 10'h040);
      initMem[10'h040] = 32'h0000_6400;
      applyStimulus("corrupt", 10'h020, 8, 1, 1, 1'b0);

      clearImage();
      initMem[10'h020] = mkNode(4'h8, 2'd0, 10'h040);
      initMem[10'h040] = mkNode(4'h9, 2'd1, 10'h020);
      applyStimulus("loop2", 10'h020, 12, 2, 1, 1'b0);

      clearImage();
      for (int i = 0; i < 64; i++)
         initMem[10'h200 + i] = mkNode(4'(i), 2'(i), (i == 63) ? 10'h000 : 10'(10'h201 + i));
      applyStimulus("chain64", 10'h200, 257, 64, 0, 1'b0);

      clearImage();
      for (int i = 0; i < 70; i++)
         initMem[10'h100 + i] = mkNode(4'(i), 2'(i), 10'(10'h100 + ((i + 1) % 70)));
      applyStimulus("ring70", 10'h100, 257, 64, 1, 1'b0);

      resetMidWalk();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
